// File: rtl/shift_reg_pkg.sv
// Shared types for the parameterised shift register.
// Mode and burst-engine state encodings.
package shift_reg_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_CLR  = 3'b110,
    M_ASR  = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } burst_state_e;

endpackage

// File: rtl/param_shift_register_shift_unit.sv
// Combinational next-value and shifted-out bit for one operation.
// Shared by the manual path and the burst engine.
module shift_unit
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_e             i_mode,
  input  logic [WIDTH-1:0]  i_q,
  input  logic [WIDTH-1:0]  i_d,
  input  logic              i_sin,
  output logic [WIDTH-1:0]  o_q,
  output logic              o_sout,
  output logic              o_sout_we
);

  always_comb begin
    o_q       = i_q;
    o_sout    = 1'b0;
    o_sout_we = 1'b0;
    unique case (i_mode)
      M_HOLD: o_q = i_q;
      M_LOAD: o_q = i_d;
      M_SHL: begin
        o_q       = {i_q[WIDTH-2:0], i_sin};
        o_sout    = i_q[WIDTH-1];
        o_sout_we = 1'b1;
      end
      M_SHR: begin
        o_q       = {i_sin, i_q[WIDTH-1:1]};
        o_sout    = i_q[0];
        o_sout_we = 1'b1;
      end
      M_ROL: begin
        o_q       = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
        o_sout    = i_q[WIDTH-1];
        o_sout_we = 1'b1;
      end
      M_ROR: begin
        o_q       = {i_q[0], i_q[WIDTH-1:1]};
        o_sout    = i_q[0];
        o_sout_we = 1'b1;
      end
      M_CLR: o_q = '0;
      M_ASR: begin
        o_q       = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
        o_sout    = i_q[0];
        o_sout_we = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/param_shift_register.sv
// WIDTH-bit multi-mode register with an autonomous burst shifter.
// Burst start takes priority over manual operations.
module param_shift_register
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              burst_dir,
  output logic [WIDTH-1:0]  q,
  output logic              sout,
  output logic              busy,
  output logic              done,
  output logic              zero
);

  burst_state_e     r_state;
  burst_state_e     w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic             r_done;
  logic             r_dir;
  logic [CNT_W-1:0] r_cnt;

  logic             w_idle;
  logic             w_shift;
  logic             w_start_go;
  logic             w_start_nil;
  logic             w_man;
  logic             w_last;
  mode_e            w_mode;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_sout_nxt;
  logic             w_sout_we;

  assign w_idle      = (r_state == S_IDLE);
  assign w_shift     = (r_state == S_SHIFT);
  assign w_start_go  = w_idle & start & (burst_len != '0);
  assign w_start_nil = w_idle & start & (burst_len == '0);
  assign w_man       = w_idle & ~start & en;
  assign w_last      = w_shift & (r_cnt == CNT_W'(1));

  // Burst steals the shift unit with a direction-derived mode
  assign w_mode = w_shift ? (r_dir ? M_SHR : M_SHL)
                          : mode_e'(mode);

  shift_unit #(
    .WIDTH (WIDTH)
  ) u_shift (
    .i_mode    (w_mode),
    .i_q       (r_q),
    .i_d       (d),
    .i_sin     (sin),
    .o_q       (w_q_nxt),
    .o_sout    (w_sout_nxt),
    .o_sout_we (w_sout_we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start_go) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last)     w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= RESET_VAL;
      r_sout <= 1'b0;
      r_done <= 1'b0;
      r_dir  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= w_last | w_start_nil;
      if (w_start_go) begin
        r_cnt <= burst_len;
        r_dir <= burst_dir;
      end else if (w_shift) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_man | w_shift) begin
        r_q <= w_q_nxt;
        if (w_sout_we) r_sout <= w_sout_nxt;
      end
    end
  end

  always_comb begin
    q    = r_q;
    sout = r_sout;
    busy = w_shift;
    done = r_done;
    zero = (r_q == '0);
  end

endmodule

// File: tb/tb_param_shift_register.sv
// Directed and random checks of param_shift_register
// against a cycle-level behavioural model.
module tb_param_shift_register;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin;
  logic       start;
  logic [3:0] burst_len;
  logic       burst_dir;
  logic [7:0] q;
  logic       sout;
  logic       busy;
  logic       done;
  logic       zero;

  int n_chk  = 0;
  int n_fail = 0;

  int m_q;
  int m_sout;
  int m_left;
  int m_dir;
  int m_cool;
  int m_done;

  param_shift_register #(
    .WIDTH     (8),
    .CNT_W     (4),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .d         (d),
    .sin       (sin),
    .start     (start),
    .burst_len (burst_len),
    .burst_dir (burst_dir),
    .q         (q),
    .sout      (sout),
    .busy      (busy),
    .done      (done),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q    = 0;
    m_sout = 0;
    m_left = 0;
    m_dir  = 0;
    m_cool = 0;
    m_done = 0;
  endtask

  task automatic model_op(input int op, input int s);
    case (op)
      1: m_q = d;
      2: begin m_sout = m_q / 128; m_q = (m_q * 2) % 256 + s; end
      3: begin m_sout = m_q % 2; m_q = m_q / 2 + s * 128; end
      4: begin m_sout = m_q / 128; m_q = (m_q * 2) % 256 + m_q / 128; end
      5: begin m_sout = m_q % 2; m_q = m_q / 2 + (m_q % 2) * 128; end
      6: m_q = 0;
      7: begin m_sout = m_q % 2; m_q = m_q / 2 + (m_q / 128) * 128; end
      default: ;
    endcase
  endtask

  task automatic model_step();
    int nd;
    nd = 0;
    if (m_left > 0) begin
      model_op(m_dir ? 3 : 2, int'(sin));
      m_left--;
      if (m_left == 0) begin
        nd     = 1;
        m_cool = 1;
      end
    end else if (m_cool != 0) begin
      m_cool = 0;
    end else if (start) begin
      if (burst_len == 0) nd = 1;
      else begin
        m_left = burst_len;
        m_dir  = burst_dir;
      end
    end else if (en) begin
      model_op(int'(mode), int'(sin));
    end
    m_done = nd;
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".q"},    32'(q),    32'(m_q));
    chk({tag, ".sout"}, 32'(sout), 32'(m_sout));
    chk({tag, ".busy"}, 32'(busy), 32'(m_left > 0));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".zero"}, 32'(zero), 32'(m_q == 0));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    cmp_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 3'd0; d = 8'h00;
    sin = 1'b0; start = 1'b0; burst_len = 4'd0; burst_dir = 1'b0;
    model_reset();
    #3;
    cmp_all("rst");
    @(posedge clk); #1;
    cmp_all("rst_hold");
    rst_n = 1'b1;

    en = 1'b1; mode = 3'd1; d = 8'hA5;
    step("load");
    chk("load_q", 32'(q), 32'h A5);
    chk("load_zero", 32'(zero), 32'd0);

    mode = 3'd2; sin = 1'b1;
    step("shl");
    chk("shl_q", 32'(q), 32'h4B);
    chk("shl_sout", 32'(sout), 32'd1);

    mode = 3'd3; sin = 1'b0;
    step("shr");
    chk("shr_q", 32'(q), 32'h25);
    chk("shr_sout", 32'(sout), 32'd1);

    mode = 3'd1; d = 8'h80; step("ld80");
    mode = 3'd7; step("asr");
    chk("asr_q", 32'(q), 32'hC0);
    chk("asr_sout", 32'(sout), 32'd0);

    mode = 3'd1; d = 8'h81; step("ld81a");
    mode = 3'd4; step("rol");
    chk("rol_q", 32'(q), 32'h03);

    mode = 3'd1; d = 8'h81; step("ld81b");
    mode = 3'd5; step("ror");
    chk("ror_q", 32'(q), 32'hC0);

    mode = 3'd6; step("clr");
    chk("clr_q", 32'(q), 32'h00);
    chk("clr_zero", 32'(zero), 32'd1);

    mode = 3'd1; d = 8'h5A; step("ld5a");
    en = 1'b0; d = 8'hFF; step("en0");
    chk("en0_q", 32'(q), 32'h5A);

    en = 1'b1; mode = 3'd1; d = 8'h01; step("ld01");
    d = 8'hFF; start = 1'b1; burst_len = 4'd3;
    burst_dir = 1'b0; sin = 1'b0;
    step("b_start");
    chk("b_start_q", 32'(q), 32'h01);
    chk("b_start_busy", 32'(busy), 32'd1);
    start = 1'b0;
    step("b1");
    chk("b1_q", 32'(q), 32'h02);
    step("b2");
    chk("b2_q", 32'(q), 32'h04);
    chk("b2_busy", 32'(busy), 32'd1);
    step("b3");
    chk("b3_q", 32'(q), 32'h08);
    chk("b3_busy", 32'(busy), 32'd0);
    chk("b3_done", 32'(done), 32'd1);
    en = 1'b0;
    step("b4");
    chk("b4_done", 32'(done), 32'd0);

    start = 1'b1; burst_len = 4'd0;
    step("z_start");
    chk("z_done", 32'(done), 32'd1);
    chk("z_busy", 32'(busy), 32'd0);
    chk("z_q", 32'(q), 32'h08);
    start = 1'b0;
    step("z_after");

    start = 1'b1; burst_len = 4'd5;
    burst_dir = 1'b1; sin = 1'b1;
    step("r_start");
    start = 1'b0;
    step("r1");
    step("r2");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("r_async_q", 32'(q), 32'h00);
    chk("r_async_busy", 32'(busy), 32'd0);
    chk("r_async_done", 32'(done), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    step("r_rel");
    chk("r_rel_done", 32'(done), 32'd0);

    for (int i = 0; i < 400; i++) begin
      en        = 1'($urandom % 2);
      mode      = 3'($urandom % 8);
      d         = 8'($urandom);
      sin       = 1'($urandom % 2);
      start     = ($urandom % 8) == 0;
      burst_len = 4'($urandom % 16);
      burst_dir = 1'($urandom % 2);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/param_shift_register.md
Name: param_shift_register

Overview:
- Next-generation storage element: generalises the single-bit D flip-flop to a WIDTH-bit register with selectable operating modes.
- Modes: hold, parallel load, shift, rotate, arithmetic shift, clear.
- Adds an autonomous burst engine that performs a programmed number of shifts with busy/done status.
- Used as a datapath building block for serialisers, scramblers and test-pattern generators.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of burst shift-count input (max burst 2^CNT_W-1).
- RESET_VAL, 0, value of q after reset (WIDTH bits).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  manual-mode enable; ignored while busy
- mode  in  3  operation select (encoding below)
- d  in  WIDTH  parallel load data
- sin  in  1  serial input for SHL/SHR
- start  in  1  burst start pulse
- burst_len  in  CNT_W  number of shifts in burst
- burst_dir  in  1  burst direction: 0 left, 1 right
- q  out  WIDTH  register contents
- sout  out  1  bit shifted out on the last shift (registered)
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse when a burst completes
- zero  out  1  combinational, q == 0

Behaviour:
- Reset: the block uses one clock, clk, with an asynchronous active-low reset, rst_n. While rst_n=0: q=RESET_VAL, sout=0, busy=0, done=0, FSM=IDLE, counter=0. Reset asserted mid-burst aborts the burst immediately and no done pulse is produced.
- mode encoding, applied on a rising edge when en=1 and FSM=IDLE:
  - 000 HOLD
  - 001 LOAD: q<=d
  - 010 SHL: q<={q[W-2:0],sin}, sout<=q[W-1]
  - 011 SHR: q<={sin,q[W-1:1]}, sout<=q[0]
  - 100 ROL
  - 101 ROR
  - 110 CLEAR: q<=0
  - 111 ASR: q<={q[W-1],q[W-1:1]}, sout<=q[0]
- Rotates set sout to the bit that wraps around.
- en=0: q and sout hold.
- Latency: one cycle from the sampled edge to q.
- FSM states:
  - IDLE: start=1 and burst_len!=0 -> SHIFT. Counter<=burst_len, direction latched, busy<=1 on the same edge. start=1 with burst_len==0 -> stay IDLE, done pulses one cycle, q unchanged. start has priority over en/mode in the same cycle.
  - SHIFT: each cycle perform one shift (left or right per latched direction, sin used as fill) and decrement the counter. The edge that performs the last shift (counter==1) -> DONE.
  - DONE: one cycle with busy=0 and done=1 -> IDLE.
- Timing: a burst of N takes N cycles of busy=1; done is asserted in cycle N+1; start is accepted again in the DONE cycle's following edge.
- While busy: start, en and mode are ignored; burst_len and burst_dir are sampled only at start.
- Counter arithmetic is unsigned CNT_W bits, with no wrap: a burst ends exactly at 0.
- zero is combinational from q.

Decomposition:
- Shared package shift_reg_pkg:
  - mode_e enum (the eight modes above)
  - burst_state_e enum (IDLE, SHIFT, DONE)
  - MODE_W=3 constant
- Natural sub-module: shift_unit. Purely combinational next-value/sout generation for a given mode, q and sin; instantiated once and shared by the manual path and the burst path.

Test Plan:
- Reset/load: assert rst_n=0 mid-operation -> q=RESET_VAL immediately, asynchronously. Release reset, en=1, LOAD d=8'hA5 -> q=8'hA5 after one edge; zero=0.
- Shifts: q=8'hA5. SHL sin=1 -> q=8'h4B, sout=1. SHR sin=0 -> q=8'h25, sout=1. ASR on 8'h80 -> q=8'hC0, sout=0.
- Rotate/clear/hold: q=8'h81, ROL -> 8'h03. ROR on 8'h81 -> 8'hC0. CLEAR -> q=0, zero=1. en=0 with mode=LOAD -> q unchanged.
- Burst: q=8'h01, start, burst_len=3, dir=0, sin=0 -> busy high for 3 cycles, q goes 02, 04, 08, then done pulses once. en/LOAD asserted during busy is ignored.
- Edge cases: start with burst_len=0 -> done pulse, busy stays 0, q held. start and en=1 LOAD in the same cycle -> burst wins. rst_n low during burst -> busy=0, no done pulse, q=RESET_VAL.
